// File: rtl/zn_seq_alu.sv
// rtl/zn_seq_alu.sv - handshaked Z16-family ALU with iterative shift-add MUL and restoring DIV
module zn_seq_alu #(
    parameter int WIDTH    = 16,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_ctrl,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_dbz
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;

    // CALC is the single cycle that registers the result on its way into DONE
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] fast_prod;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [3:0]       op_in;
    logic             iter_in;
    logic [WIDTH-1:0] res;

    assign add_full  = {1'b0, a_q} + {1'b0, b_q};
    assign fast_prod = b_q * a_q;
    // Restoring step: B shifts out MSB-first into the remainder, quotient bits shift into B
    assign div_shift = {acc_q, b_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, a_q};

    assign op_in   = (i_ctrl > OP_SHR) ? OP_ADD : i_ctrl;
    assign iter_in = ((op_in == OP_DIV) && (i_data_a != '0)) ||
                     ((op_in == OP_MUL) && !FAST_MUL);

    always_comb begin
        res = '0;
        case (op_q)
            OP_SUB:  res = b_q - a_q;
            OP_MUL:  res = FAST_MUL ? fast_prod : acc_q;
            OP_DIV:  res = (a_q == '0) ? '1 : b_q;
            OP_OR:   res = b_q | a_q;
            OP_AND:  res = b_q & a_q;
            OP_XOR:  res = b_q ^ a_q;
            OP_SHL:  res = a_q << b_q[SW-1:0];
            OP_SHR:  res = a_q >> b_q[SW-1:0];
            default: res = add_full[WIDTH-1:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        data_d  = data_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    op_d    = op_in;
                    a_d     = i_data_a;
                    b_d     = i_data_b;
                    acc_d   = '0;
                    cnt_d   = SW'(WIDTH - 1);
                    state_d = iter_in ? S_BUSY : S_CALC;
                end
            end
            S_BUSY: begin
                if (op_q == OP_MUL) begin
                    if (b_q[0]) acc_d = acc_q + a_q;
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                end else if (!div_diff[WIDTH]) begin
                    acc_d = div_diff[WIDTH-1:0];
                    b_d   = {b_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift[WIDTH-1:0];
                    b_d   = {b_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) state_d = S_CALC;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CALC: begin
                data_d  = res;
                zero_d  = (res == '0);
                carry_d = (op_q == OP_ADD) ? add_full[WIDTH] :
                          (op_q == OP_SUB) ? (a_q > b_q) : 1'b0;
                dbz_d   = (op_q == OP_DIV) && (a_q == '0);
                state_d = S_DONE;
            end
            default: begin
                if (i_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            dbz_q   <= dbz_d;
        end
    end

    assign o_ready = (state_q == S_IDLE);
    assign o_valid = (state_q == S_DONE);
    assign o_data  = data_q;
    assign o_zero  = zero_q;
    assign o_carry = carry_q;
    assign o_dbz   = dbz_q;

endmodule
